// File: rtl/axi_sram_arbiter.sv
// ---------------------------------------------------------------------------
// axi_sram_arbiter
//   Two-requester AXI-Lite arbiter in front of a single SRAM controller port.
//   Exactly one transaction (read or write, from either requester) is carried
//   to the out_* master port at a time. A round-robin pointer (last_r) breaks
//   ties between requesters; within one requester a write beats a read.
//
// Ports
//   axi_clk, axi_resetn       : clock (rising edge), async active-low reset
//   in0_* / in1_*             : AXI-Lite slave ports for requesters 0 and 1
//                               (aw, w, b, ar, r channels; wstrb is 1 bit)
//   out_*                     : AXI-Lite master port to the SRAM controller
// ---------------------------------------------------------------------------
module axi_sram_arbiter #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                      axi_clk,
  input  logic                      axi_resetn,
  // requester 0
  input  logic [AXI_ADDR_WIDTH-1:0] in0_awaddr,
  input  logic                      in0_awvalid,
  output logic                      in0_awready,
  input  logic [AXI_DATA_WIDTH-1:0] in0_wdata,
  input  logic                      in0_wstrb,
  input  logic                      in0_wvalid,
  output logic                      in0_wready,
  output logic [1:0]                in0_bresp,
  output logic                      in0_bvalid,
  input  logic                      in0_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] in0_araddr,
  input  logic                      in0_arvalid,
  output logic                      in0_arready,
  output logic [AXI_DATA_WIDTH-1:0] in0_rdata,
  output logic [1:0]                in0_rresp,
  output logic                      in0_rvalid,
  input  logic                      in0_rready,
  // requester 1
  input  logic [AXI_ADDR_WIDTH-1:0] in1_awaddr,
  input  logic                      in1_awvalid,
  output logic                      in1_awready,
  input  logic [AXI_DATA_WIDTH-1:0] in1_wdata,
  input  logic                      in1_wstrb,
  input  logic                      in1_wvalid,
  output logic                      in1_wready,
  output logic [1:0]                in1_bresp,
  output logic                      in1_bvalid,
  input  logic                      in1_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] in1_araddr,
  input  logic                      in1_arvalid,
  output logic                      in1_arready,
  output logic [AXI_DATA_WIDTH-1:0] in1_rdata,
  output logic [1:0]                in1_rresp,
  output logic                      in1_rvalid,
  input  logic                      in1_rready,
  // master port to the SRAM controller
  output logic [AXI_ADDR_WIDTH-1:0] out_awaddr,
  output logic                      out_awvalid,
  input  logic                      out_awready,
  output logic [AXI_DATA_WIDTH-1:0] out_wdata,
  output logic                      out_wstrb,
  output logic                      out_wvalid,
  input  logic                      out_wready,
  input  logic [1:0]                out_bresp,
  input  logic                      out_bvalid,
  output logic                      out_bready,
  output logic [AXI_ADDR_WIDTH-1:0] out_araddr,
  output logic                      out_arvalid,
  input  logic                      out_arready,
  input  logic [AXI_DATA_WIDTH-1:0] out_rdata,
  input  logic [1:0]                out_rresp,
  input  logic                      out_rvalid,
  output logic                      out_rready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t state_r;
  logic   grant_r;     // requester currently owning out_*
  logic   last_r;      // requester granted most recently (round-robin pointer)
  logic   aw_done_r;   // aw handshake of the current write already forwarded
  logic   w_done_r;    // w handshake of the current write already forwarded

  logic req0_wr_s, req0_any_s, req1_wr_s, req1_any_s;
  logic pick_s, pick_wr_s;
  logic is_write_s, is_read_s;

  assign req0_wr_s  = in0_awvalid & in0_wvalid;
  assign req1_wr_s  = in1_awvalid & in1_wvalid;
  assign req0_any_s = req0_wr_s | in0_arvalid;
  assign req1_any_s = req1_wr_s | in1_arvalid;
  assign is_write_s = (state_r == ST_WRITE);
  assign is_read_s  = (state_r == ST_READ);

  // Requester choice in IDLE: on a tie the one that was not served last wins.
  always_comb begin
    pick_s = 1'b0;
    if (req0_any_s && req1_any_s) begin
      pick_s = ~last_r;
    end else if (req1_any_s) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // A write beats a simultaneous read from the same requester.
  assign pick_wr_s = pick_s ? req1_wr_s : req0_wr_s;

  // Address/data always follow the granted requester, so they match whenever
  // the corresponding out_* valid is high.
  assign out_awaddr = grant_r ? in1_awaddr : in0_awaddr;
  assign out_wdata  = grant_r ? in1_wdata  : in0_wdata;
  assign out_wstrb  = grant_r ? in1_wstrb  : in0_wstrb;
  assign out_araddr = grant_r ? in1_araddr : in0_araddr;

  // Valids toward the SRAM; aw/w are held off once their handshake is done.
  assign out_awvalid = is_write_s & ~aw_done_r & (grant_r ? in1_awvalid : in0_awvalid);
  assign out_wvalid  = is_write_s & ~w_done_r  & (grant_r ? in1_wvalid  : in0_wvalid);
  assign out_bready  = is_write_s & (grant_r ? in1_bready : in0_bready);
  assign out_arvalid = is_read_s  & (grant_r ? in1_arvalid : in0_arvalid);
  assign out_rready  = is_read_s  & (grant_r ? in1_rready  : in0_rready);

  // Return path: only the granted requester ever sees ready/valid.
  assign in0_awready = is_write_s & ~grant_r & ~aw_done_r & out_awready;
  assign in0_wready  = is_write_s & ~grant_r & ~w_done_r  & out_wready;
  assign in0_bvalid  = is_write_s & ~grant_r & out_bvalid;
  assign in0_arready = is_read_s  & ~grant_r & out_arready;
  assign in0_rvalid  = is_read_s  & ~grant_r & out_rvalid;
  assign in1_awready = is_write_s &  grant_r & ~aw_done_r & out_awready;
  assign in1_wready  = is_write_s &  grant_r & ~w_done_r  & out_wready;
  assign in1_bvalid  = is_write_s &  grant_r & out_bvalid;
  assign in1_arready = is_read_s  &  grant_r & out_arready;
  assign in1_rvalid  = is_read_s  &  grant_r & out_rvalid;

  assign in0_bresp = out_bresp;
  assign in1_bresp = out_bresp;
  assign in0_rdata = out_rdata;
  assign in1_rdata = out_rdata;
  assign in0_rresp = out_rresp;
  assign in1_rresp = out_rresp;

  // Arbitration FSM: grant, round-robin pointer and per-channel done flags.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r   <= ST_IDLE;
      grant_r   <= 1'b0;
      last_r    <= 1'b1;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          if (req0_any_s || req1_any_s) begin
            grant_r <= pick_s;
            last_r  <= pick_s;
            state_r <= pick_wr_s ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (out_awvalid && out_awready) begin
            aw_done_r <= 1'b1;
          end
          if (out_wvalid && out_wready) begin
            w_done_r <= 1'b1;
          end
          if (out_bvalid && out_bready) begin
            state_r   <= ST_IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end
        end
        ST_READ: begin
          if (out_rvalid && out_rready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
